// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared state type and constants for the instruction fetch unit
package if_fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_e;
  localparam int PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: power-of-two circular buffer with synchronous clear and occupancy count
module if_fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           push_data,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: sequential instruction fetch with bounded outstanding requests,
// a small decode buffer and redirect flushing of in-flight responses
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEFAULT_RESET_PC),
  parameter int              BUF_DEPTH = 2,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            go,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            do_stall
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_e state;
  logic [XLEN-1:0] pc, rsp_pc;
  logic [CW-1:0] outst, disc, occ;
  logic [CW:0] inflight;
  logic [2*XLEN-1:0] head;
  logic req_fire, push, pop;
  // Reserving buffer space at issue time means a response can never be refused.
  assign inflight = outst + occ;
  assign imem_req_valid = state == RUN && go && !redirect &&
                          inflight < (CW+1)'(BUF_DEPTH) && outst < CW'(MAX_OUTST);
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && state != FLUSH && !redirect;
  assign pop = id_valid && id_ready && !redirect;
  assign id_valid = occ != '0;
  assign id_inst = id_valid ? head[XLEN-1:0] : '0;
  assign id_pc = id_valid ? head[2*XLEN-1:XLEN] : '0;
  assign do_stall = state == FLUSH || (go && !id_valid);
  if_fetch_fifo #(.W(2*XLEN), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk, .reset_n, .clear(redirect), .push, .pop,
    .push_data({rsp_pc, imem_rsp_data}), .head, .count(occ)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst <= '0;
      disc <= '0;
    end else begin
      outst <= outst + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect) begin
        pc <= redirect_pc;
        rsp_pc <= redirect_pc;
      end else begin
        if (req_fire) pc <= pc + XLEN'(PC_INC);
        if (push) rsp_pc <= rsp_pc + XLEN'(PC_INC);
      end
      // While flushing, every response belongs to the abandoned stream.
      if (state == FLUSH) begin
        disc <= disc - CW'(imem_rsp_valid);
        if (imem_rsp_valid && disc == CW'(1)) state <= go ? RUN : IDLE;
      end else if (redirect) begin
        disc <= outst - CW'(imem_rsp_valid);
        state <= outst != CW'(imem_rsp_valid) ? FLUSH : go ? RUN : IDLE;
      end else if (state == IDLE) begin
        if (go) state <= RUN;
      end else if (!go && outst == '0) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of if_fetch_unit against a
// transaction-level model of requests, in-flight words and the decode buffer
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  localparam int DEPTH = 2;
  localparam int MAXO = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 0, reset_n = 1, go = 0, redirect = 0;
  logic imem_req_ready = 0, imem_rsp_valid = 0, id_ready = 0;
  logic [31:0] redirect_pc = '0, imem_rsp_data = '0;
  logic imem_req_valid, id_valid, do_stall;
  logic [31:0] imem_req_addr, id_inst, id_pc;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] q_addr[$];
  bit q_stale[$];
  int q_cyc[$];
  logic [31:0] b_pc[$];
  logic [31:0] seen[$], fired[$];
  logic [31:0] m_pc;
  bit m_run;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .RESET_PC(RPC), .BUF_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .do_stall(do_stall)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset_n = 0; go = 0; redirect = 0; imem_req_ready = 0; imem_rsp_valid = 0; id_ready = 0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_id_inst", id_inst, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_do_stall", 32'(do_stall), 0);
    q_addr.delete(); q_stale.delete(); q_cyc.delete(); b_pc.delete();
    m_pc = RPC; m_run = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input bit g, input bit rd, input logic [31:0] rpc, input bit idr,
                      input bit rqr, input bit rsp_en);
    bit flushing, rv, fire, rsp, deq;
    @(negedge clk);
    go = g; redirect = rd; redirect_pc = rpc; id_ready = idr; imem_req_ready = rqr;
    rsp = rsp_en && q_addr.size() > 0 && q_cyc[0] < cyc;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word_at(q_addr[0]) : '0;
    #1;
    flushing = 0;
    foreach (q_stale[i]) if (q_stale[i]) flushing = 1;
    rv = m_run && g && !rd && !flushing && (q_addr.size() + b_pc.size() < DEPTH) && q_addr.size() < MAXO;
    check("req_valid", 32'(imem_req_valid), 32'(rv));
    if (rv) check("req_addr", imem_req_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(b_pc.size() > 0));
    if (b_pc.size() > 0) begin
      check("id_pc", id_pc, b_pc[0]);
      check("id_inst", id_inst, word_at(b_pc[0]));
    end
    check("do_stall", 32'(do_stall), 32'(flushing || (g && b_pc.size() == 0)));
    if (imem_req_valid && rqr) fired.push_back(imem_req_addr);
    if (id_valid && idr && !rd) seen.push_back(id_pc);
    fire = rv && rqr;
    deq = b_pc.size() > 0 && idr && !rd;
    m_run = g || (m_run && !flushing && !rd && q_addr.size() > 0);
    if (deq) void'(b_pc.pop_front());
    if (rsp) begin
      if (!q_stale[0] && !rd) b_pc.push_back(q_addr[0]);
      void'(q_addr.pop_front()); void'(q_stale.pop_front()); void'(q_cyc.pop_front());
    end
    if (rd) begin
      b_pc.delete();
      foreach (q_stale[i]) q_stale[i] = 1;
      m_pc = rpc;
    end else if (fire) begin
      q_addr.push_back(m_pc); q_stale.push_back(0); q_cyc.push_back(cyc);
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    #2;
    do_reset();
    // straight-line fetch with single-cycle memory
    seen.delete();
    repeat (12) step(1, 0, 0, 1, 1, 1);
    check("seq_len", 32'(seen.size() >= 3), 1);
    if (seen.size() >= 3) begin
      check("seq0", seen[0], 32'h0);
      check("seq1", seen[1], 32'h4);
      check("seq2", seen[2], 32'h8);
    end
    // decode stalled: buffer fills, requests stop
    do_reset();
    fired.delete();
    repeat (10) step(1, 0, 0, 0, 1, 1);
    check("stall_nreq", fired.size(), 2);
    if (fired.size() == 2) begin
      check("stall_req0", fired[0], 32'h0);
      check("stall_req1", fired[1], 32'h4);
    end
    repeat (6) step(1, 0, 0, 1, 1, 1);
    // redirect with two outstanding
    do_reset();
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 1, 32'h100, 0, 1, 0);
    #1 check("flush_state", 32'(dut.state), 32'(FLUSH));
    seen.delete();
    repeat (10) step(1, 0, 0, 1, 1, 1);
    check("flush_seen", 32'(seen.size() > 0), 1);
    if (seen.size() > 0) check("flush_first_pc", seen[0], 32'h100);
    // redirect coincident with a response and dequeue
    do_reset();
    repeat (3) step(1, 0, 0, 1, 1, 0);
    fired.delete();
    step(1, 1, 32'h200, 1, 1, 1);
    #1 check("redir_rsp_empty", 32'(id_valid), 0);
    repeat (3) step(1, 0, 0, 1, 1, 1);
    check("redir_rsp_nreq", 32'(fired.size() > 0), 1);
    if (fired.size() > 0) check("redir_rsp_addr", fired[0], 32'h200);
    // address wrap
    do_reset();
    step(1, 0, 0, 1, 1, 1);
    fired.delete(); seen.delete();
    step(1, 1, 32'hFFFF_FFFC, 1, 1, 1);
    repeat (8) step(1, 0, 0, 1, 1, 1);
    check("wrap_nreq", 32'(fired.size() >= 2), 1);
    if (fired.size() >= 2) begin
      check("wrap_req0", fired[0], 32'hFFFF_FFFC);
      check("wrap_req1", fired[1], 32'h0);
    end
    if (seen.size() >= 2) check("wrap_id_pc1", seen[1], 32'h0);
    // reset while flushing
    do_reset();
    repeat (3) step(1, 0, 0, 0, 1, 0);
    step(1, 1, 32'h300, 0, 1, 0);
    do_reset();
    fired.delete();
    repeat (4) step(1, 0, 0, 1, 1, 1);
    check("post_rst_nreq", 32'(fired.size() > 0), 1);
    if (fired.size() > 0) check("post_rst_addr", fired[0], RPC);
    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
      step(i % 300 < 260 ? $urandom_range(0, 15) != 0 : $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
